// File: rtl/morse_pkg.sv
// Shared types and the S..Z letter table for the Morse transmitter.
// Each pattern is sent bit 0 first; 1 = light on.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   localparam int CODE_W = 13;

   localparam logic [CODE_W-1:0] LETTER_PAT [8] = '{
      13'h0015, 13'h0007, 13'h0075, 13'h01D5,
      13'h01DD, 13'h0757, 13'h1DD7, 13'h0577
   };

   localparam logic [3:0] LETTER_LEN [8] = '{
      4'd5, 4'd3, 4'd7, 4'd9,
      4'd9, 4'd11, 4'd13, 4'd11
   };

endpackage

// File: rtl/morse_lut.sv
// Combinational letter lookup: select in, zero-extended pattern and length out.
module morse_lut
   import morse_pkg::*;
#(
   parameter int PAT_W = 16
) (
   input  logic [2:0]       sel,
   output logic [PAT_W-1:0] pat,
   output logic [3:0]       len
);

   always_comb begin
      pat = PAT_W'(LETTER_PAT[sel]);
      len = LETTER_LEN[sel];
   end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter for letters S..Z: symbol timer, control FSM and shift register,
// with busy/done handshake, abort and repeat-with-gap mode.
module morse_tx
   import morse_pkg::*;
#(
   parameter int TICK_CYCLES = 25_000_000,
   parameter int PAT_W       = 16,
   parameter int GAP_TICKS   = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [2:0] sel,
   input  logic       repeat_en,
   input  logic       abort,
   output logic       led_out,
   output logic       busy,
   output logic       done
);

   localparam int TW = $clog2(TICK_CYCLES);
   localparam int BW = $clog2(PAT_W + 1);
   localparam int GW = $clog2(GAP_TICKS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

   state_t           state, state_next;
   logic [PAT_W-1:0] shreg, shreg_next;
   logic [BW-1:0]    bcnt, bcnt_next;
   logic [GW-1:0]    gcnt, gcnt_next;
   logic [TW-1:0]    tcnt, tcnt_next;
   logic [2:0]       sel_q, sel_q_next;
   logic             done_next;

   logic [2:0]       lut_sel;
   logic [PAT_W-1:0] lut_pat;
   logic [3:0]       lut_len;
   logic             tick;

   // Fresh letters use the live select; repetitions replay the captured one.
   assign lut_sel = (state == IDLE) ? sel : sel_q;

   morse_lut #(
      .PAT_W(PAT_W)
   ) u_lut (
      .sel(lut_sel),
      .pat(lut_pat),
      .len(lut_len)
   );

   assign tick = (tcnt == '0);

   always_comb begin
      state_next = state;
      shreg_next = shreg;
      bcnt_next  = bcnt;
      gcnt_next  = gcnt;
      tcnt_next  = tcnt;
      sel_q_next = sel_q;
      done_next  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = SEND;
               sel_q_next = sel;
               shreg_next = lut_pat;
               bcnt_next  = BW'(lut_len);
               tcnt_next  = TICK_LAST;
            end
         end
         SEND: begin
            if (!tick) begin
               tcnt_next = tcnt - TW'(1);
            end else begin
               tcnt_next = TICK_LAST;
               if (bcnt > BW'(1)) begin
                  shreg_next = shreg >> 1;
                  bcnt_next  = bcnt - BW'(1);
               end else if (repeat_en) begin
                  state_next = GAP;
                  gcnt_next  = GAP_LOAD;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         GAP: begin
            if (!tick) begin
               tcnt_next = tcnt - TW'(1);
            end else begin
               tcnt_next = TICK_LAST;
               gcnt_next = gcnt - GW'(1);
               if (gcnt == GW'(1)) begin
                  state_next = SEND;
                  shreg_next = lut_pat;
                  bcnt_next  = BW'(lut_len);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort wins over every transition, including a start seen in IDLE.
      if (abort) begin
         state_next = IDLE;
         shreg_next = '0;
         done_next  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         shreg <= '0;
         bcnt  <= '0;
         gcnt  <= '0;
         tcnt  <= '0;
         sel_q <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         shreg <= shreg_next;
         bcnt  <= bcnt_next;
         gcnt  <= gcnt_next;
         tcnt  <= tcnt_next;
         sel_q <= sel_q_next;
         done  <= done_next;
      end
   end

   // Decoded from registers only, so reset clears them without waiting for a clock.
   assign led_out = (state == SEND) && shreg[0];
   assign busy    = (state != IDLE);

endmodule

// File: doc/morse_tx.md
# morse_tx

Parametrised Morse-code transmitter for the letters S–Z. On a `start` strobe it latches a 3-bit letter select, looks up that letter's on/off pattern and its length, and serialises the pattern LSB-first on `led_out` at one symbol per `TICK_CYCLES` clocks. It can then stop with a `done` pulse, or repeat with an inter-letter gap. It sits between board switches/keys and a LED, and adds `busy`/`done` handshaking, abort and repeat mode over the fixed 13-bit, free-running encoder.

## Interface
- `TICK_CYCLES`, default 25_000_000: clocks per Morse symbol (0.5 s at 50 MHz); must be ≥ 2.
- `PAT_W`, default 16: shift-register width; must be ≥ 13. Table patterns are zero-extended to this width.
- `GAP_TICKS`, default 3: symbols of forced-off time between repetitions; must be ≥ 1.
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a transmission. Sampled only in IDLE.
- `sel` in 3: letter select (0=S … 7=Z). Captured on an accepted `start`.
- `repeat_en` in 1: when 1, loop the captured letter. Sampled at end of each letter.
- `abort` in 1: synchronous stop. Has priority over everything except reset.
- `led_out` out 1: Morse output. 1 = light on.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a non-repeating letter finishes.

## Operation
- States:
  - IDLE: `led_out`=0, `busy`=0.
  - SEND: `led_out` = `shreg[0]`.
  - GAP: `led_out`=0, `busy`=1.
- Symbol timer:
  - `tcnt`, width clog2(`TICK_CYCLES`), counts down.
  - `tick` = (`tcnt`==0). On `tick`, `tcnt` reloads `TICK_CYCLES`-1.
  - `tcnt` is only reloaded on entry to SEND or GAP, so phase is aligned to `start`.
- Letter table (pattern, length), sent bit 0 first:
  - S 0x0015/5, T 0x0007/3, U 0x0075/7, V 0x01D5/9
  - W 0x01DD/9, X 0x0757/11, Y 0x1DD7/13, Z 0x0577/11
- IDLE with `start`=1 goes to SEND:
  - `sel` is latched into `sel_q`.
  - `shreg` loads pattern(`sel`); `bcnt` loads length(`sel`).
  - `tcnt` loads `TICK_CYCLES`-1.
- SEND on `tick`:
  - If `bcnt`>1: `shreg` shifts right, zero-filling, and `bcnt` decrements.
  - If `bcnt`==1 and `repeat_en`=1: go to GAP with `gcnt` = `GAP_TICKS`.
  - If `bcnt`==1 and `repeat_en`=0: go to IDLE and assert `done` for one cycle.
- GAP on `tick`:
  - `gcnt` decrements.
  - When `gcnt` hits 1, go to SEND and reload pattern/length from `sel_q` (not the live `sel`).
- `abort`=1 in any state: next cycle is IDLE, `shreg`=0, no `done`. `abort` and `start` together in IDLE: stay IDLE.
- `start` while busy: ignored, not queued.
- Width of `bcnt`: clog2(`PAT_W`+1). Length is never 0, so `bcnt` never underflows.

## Timing
- Reset (asynchronous): state=IDLE; `shreg`, `bcnt`, `gcnt`, `tcnt`, `sel_q` = 0; `led_out`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.
- `start` sampled high at edge N:
  - `busy`=1 and `led_out`=bit0 from edge N+1.
  - Each symbol lasts exactly `TICK_CYCLES` clocks.
- Non-repeat letter of length L: `done` is high during cycle N+1+L·`TICK_CYCLES`, and `busy` is 0 from that same edge.
- Repeat mode: the gap lasts `GAP_TICKS`·`TICK_CYCLES` clocks of `led_out`=0, then bit0 reappears.
- Clearing `repeat_en` mid-letter: the current letter completes, then `done` fires.
- Reset mid-transmission: `led_out` drops immediately (asynchronously).

## Structure
- Package `morse_pkg` holds:
  - the state enum `{IDLE, SEND, GAP}`;
  - `LETTER_PAT[8]` (13-bit) and `LETTER_LEN[8]` (4-bit) constants.
- Sub-module `morse_lut`: combinational; `sel` in, zero-extended pattern and length out.
- Timer, FSM and shift register live in the top level.

## Test plan
All scenarios use `TICK_CYCLES`=4 and `GAP_TICKS`=3.
- Reset then idle 50 cycles -> `led_out`, `busy`, `done` all 0.
- `start` with `sel`=0 (S), `repeat_en`=0 -> `led_out` sequence 1,0,1,0,1, each held 4 clocks; `done` pulses exactly once at cycle 21 after `start`; `busy` covers cycles 1–20.
- `sel`=6 (Y) -> 13 symbols matching 0x1DD7 LSB-first; `done` at cycle 53.
- `sel`=1 (T), `repeat_en`=1, changing `sel` to 7 mid-letter -> 1,1,1 then 12 clocks low, then T again; `done` never pulses; clearing `repeat_en` ends after the current T with one `done`.
- `start` pulsed during SEND, then `abort` at symbol 2 -> second `start` has no effect; IDLE and `led_out`=0 next cycle; no `done`.
- Assert `reset_n`=0 mid-letter, asynchronously between edges -> outputs 0 immediately; a fresh `start` after release transmits normally.
